alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Two-requester issue controller and sequencer for the shared integer ALU.
- Arbitrates between the requesters, registers operands into the combinational ALU, and returns the result with its icc flags.
- Owns the architectural icc register (N,Z,V,C) and supplies Cin to the ALU for the carry-consuming ops ADDX/SUBX.
- Sits between the integer-unit execute logic (port 0) and the address/aux datapath (port 1).

Parameters:
- W, 32, operand/result width.
- OPW, 6, op3 field width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0_valid  in  1  port 0 request
- req0_ready  out  1  port 0 accepted this cycle
- req0_op  in  OPW  port 0 op3 code
- req0_a  in  W  port 0 operand a
- req0_b  in  W  port 0 operand b
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for port 1
- alu_op  out  OPW  to ALU
- alu_a  out  W  to ALU
- alu_b  out  W  to ALU
- alu_cin  out  1  to ALU
- alu_res  in  W  from ALU
- alu_n, alu_z, alu_v, alu_c  in  1 each  from ALU
- rsp_valid  out  1  result valid
- rsp_port  out  1  originating port
- rsp_res  out  W  result
- rsp_icc  out  4  {N,Z,V,C} of this op
- icc  out  4  architectural {N,Z,V,C}
- icc_wr_en  in  1  external icc write (WRPSR)
- icc_wr_data  in  4  value for the external write

Behaviour:
- **Op classes:**
  - cc op: op[5]=0 and op[4]=1.
  - carry op: op[5]=0, op[3]=1 and op[2:0] in {000,100} (ADDX, ADDXcc, SUBX, SUBXcc).
  - Any other op3 is passed through to the ALU unchanged.
- **Arbitration:**
  - Round-robin; pointer reset to favour port 0.
  - Both valid and not stalled: grant the port opposite the last grant.
  - Single valid: grant it.
  - reqN_ready = grantN & ~stall. Handshake = valid & ready at a rising edge.
- **Stage E (issue register):**
  - Loaded at the handshake edge t with op/a/b/port and cin.
  - cin = icc.C for carry ops, 0 otherwise.
  - alu_* outputs are driven directly from E during the cycle after t.
  - E is marked empty when there is no handshake.
- **Stage W (writeback):**
  - At edge t+1, if E is valid: rsp_* are captured from alu_res and {alu_n,alu_z,alu_v,alu_c}, and rsp_valid=1 for one cycle.
  - Latency is 2 edges; throughput is 1 op/cycle. There is no response backpressure.
- **icc update:**
  - At edge t+1, icc <= ALU flags if the E op is a cc op. Non-cc ops leave icc unchanged.
  - If icc_wr_en is high on the same edge, icc_wr_data wins.
  - icc_wr_en alone writes icc at that edge.
- **Hazard:** a carry op requested while E holds a valid cc op. Handling depends on ICC_BYPASS_EN (see Optional Feature).
- **Reset (also mid-operation):**
  - E and W cleared; in-flight ops are discarded.
  - rsp_valid=0, rsp_port=0, rsp_res=0, rsp_icc=0.
  - icc=0; alu_op=0, alu_a=0, alu_b=0, alu_cin=0.
  - req*_ready=0 during reset; arbiter pointer to port 0.

Optional Feature:
- Macro: ICC_BYPASS_EN.
- **Defined:** the hazard does not stall. The carry op is accepted, and E.cin is captured from the live alu_c of the cc op currently in E.
- **Undefined:**
  - stall=1 for that cycle: ready is low for the carry-op requester, and the other port is not granted either.
  - The op is accepted on the next cycle, using the updated icc.C.
  - One bubble appears in rsp_valid.

Decomposition:
- Package alu_ctrl_pkg:
  - op3 constants: ADD, ADDcc, ADDX, ADDXcc, SUB, SUBcc, SUBX, SUBXcc, AND, OR, XOR, ANDN, ORN, XNOR.
  - ICC bit indices: N=3, Z=2, V=1, C=0.
  - Functions is_cc(op) and uses_carry(op).
- Sub-module: rr_arb2, the two-way round-robin arbiter (inputs req0/req1/stall, outputs gnt0/gnt1, internal pointer).

Test Plan:
- Port 0 ADDcc a=32'h7FFFFFFF b=1 -> after 2 edges: rsp_valid=1, rsp_port=0, rsp_res=32'h80000000, rsp_icc=4'b1010, icc=4'b1010.
- Back-to-back on port 0: ADDcc 32'hFFFFFFFF+1, then ADDX 0+0 ->
  - First op: res=0, icc=4'b0101.
  - ADDX: alu_cin=1, res=1.
  - With ICC_BYPASS_EN: consecutive rsp_valid.
  - Without it: req0_ready low for 1 cycle, one bubble.
- Both ports valid for 4 cycles with AND ops -> grants 0,1,0,1, and rsp_port follows the same sequence.
- Port 0 OR op after icc=4'b1111 -> icc remains 4'b1111.
- ADDcc writeback with icc_wr_en=1 and icc_wr_data=4'b0000 on the same edge -> icc=4'b0000.
- Assert reset with ops in E and W -> next cycle rsp_valid=0, icc=0, alu_cin=0. The discarded op never produces a response.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared definitions for the ALU issue controller.
//               - op3 encodings of the integer ops handled by the shared ALU
//               - bit positions inside the 4-bit {N,Z,V,C} condition code
//               - issue-stage control record
//               - op classification helpers is_cc() / uses_carry()
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  localparam int OP3_W = 6;

  typedef logic [OP3_W-1:0] op3_t;

  // Plain ops (bit 4 clear), their cc variants have bit 4 set.
  localparam op3_t OP_ADD    = 6'b000000;
  localparam op3_t OP_AND    = 6'b000001;
  localparam op3_t OP_OR     = 6'b000010;
  localparam op3_t OP_XOR    = 6'b000011;
  localparam op3_t OP_SUB    = 6'b000100;
  localparam op3_t OP_ANDN   = 6'b000101;
  localparam op3_t OP_ORN    = 6'b000110;
  localparam op3_t OP_XNOR   = 6'b000111;
  localparam op3_t OP_ADDX   = 6'b001000;
  localparam op3_t OP_SUBX   = 6'b001100;
  localparam op3_t OP_ADDCC  = 6'b010000;
  localparam op3_t OP_SUBCC  = 6'b010100;
  localparam op3_t OP_ADDXCC = 6'b011000;
  localparam op3_t OP_SUBXCC = 6'b011100;

  // Bit positions inside a {N,Z,V,C} nibble.
  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  // Control part of the issue stage (operands are kept separately because
  // their width is a module parameter).
  typedef struct packed {
    logic valid;
    logic port;
    op3_t op;
    logic cin;
  } issue_ctl_t;

  // Op updates the architectural icc when it completes.
  function automatic logic is_cc(input op3_t op);
    return (op[5] == 1'b0) && (op[4] == 1'b1);
  endfunction

  // Op consumes icc.C as carry-in (ADDX, ADDXcc, SUBX, SUBXcc).
  function automatic logic uses_carry(input op3_t op);
    return (op[5] == 1'b0) && (op[3] == 1'b1) &&
           ((op[2:0] == 3'b000) || (op[2:0] == 3'b100));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_if
// Description : Bundle of every non-clock signal of alu_issue_ctrl.
//               Groups: two request ports (req0_*, req1_*), the ALU operand /
//               result bus (alu_*), the response (rsp_*), the architectural
//               icc and its external write port (icc_wr_*).
//   modport slave  : the controller side
//   modport master : the surroundings (requesters, ALU, icc writer)
// Parameters  : W   operand/result width
//               OPW op3 field width
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
  parameter int W   = 32,
  parameter int OPW = 6
);

  // Request port 0 (integer-unit execute)
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;

  // Request port 1 (address / aux datapath)
  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;

  // Combinational ALU
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_cin;
  logic [W-1:0]   alu_res;
  logic           alu_n;
  logic           alu_z;
  logic           alu_v;
  logic           alu_c;

  // Response
  logic           rsp_valid;
  logic           rsp_port;
  logic [W-1:0]   rsp_res;
  logic [3:0]     rsp_icc;

  // Architectural condition codes
  logic [3:0]     icc;
  logic           icc_wr_en;
  logic [3:0]     icc_wr_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b, alu_cin,
    input  alu_res, alu_n, alu_z, alu_v, alu_c,
    output rsp_valid, rsp_port, rsp_res, rsp_icc,
    output icc,
    input  icc_wr_en, icc_wr_data
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b, alu_cin,
    output alu_res, alu_n, alu_z, alu_v, alu_c,
    input  rsp_valid, rsp_port, rsp_res, rsp_icc,
    input  icc,
    output icc_wr_en, icc_wr_data
  );

endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter.
//               With both requests active the port opposite the most recent
//               grant wins; a lone request is always granted. The history
//               only advances on a grant that is not stalled, so a stalled
//               cycle does not cost a port its turn.
// Ports       : clk, reset      clock, synchronous active-high reset
//               req0, req1      requests
//               stall           suppress history update this cycle
//               gnt0, gnt1      one-hot (or zero) grant, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic stall,
  output logic gnt0,
  output logic gnt1
);

  // 1 = port 1 was granted last. Reset value makes port 0 the favourite.
  logic last_gnt1;

  assign gnt0 = req0 & (~req1 | last_gnt1);
  assign gnt1 = req1 & (~req0 | ~last_gnt1);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt1 <= 1'b1;
    end else if (~stall && (gnt0 || gnt1)) begin
      last_gnt1 <= gnt1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Two-requester issue controller for the shared integer ALU.
//               Round-robin arbitration, an issue register (E) feeding the
//               combinational ALU, a writeback register (W) returning the
//               result and its flags, and the architectural icc register.
//               Latency: request edge t -> rsp_valid after edge t+1.
// Ports       : clk, reset  clock, synchronous active-high reset
//               bus         alu_issue_ctrl_if.slave (requests, ALU bus,
//                           response, icc and external icc write)
// Options     : ICC_BYPASS_EN - when defined, a carry op arriving behind a
//               cc op in E takes its carry-in from the live ALU carry instead
//               of stalling one cycle for icc to update.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W   = 32,
  parameter int OPW = 6
) (
  input  logic               clk,
  input  logic               reset,
  alu_issue_ctrl_if.slave    bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  issue_ctl_t   e_ctl;
  logic [W-1:0] e_a;
  logic [W-1:0] e_b;

  logic         w_valid;
  logic         w_port;
  logic [W-1:0] w_res;
  logic [3:0]   w_icc;

  logic [3:0]   icc_q;

  // --------------------------------------------------------------------------
  // Hazard / stall and carry-in source
  // --------------------------------------------------------------------------
  logic         e_cc;       // E holds a valid op that will rewrite icc
  logic         stall;
  logic         carry_src;  // carry-in for a carry op accepted this cycle

  assign e_cc = e_ctl.valid & is_cc(e_ctl.op);

`ifdef ICC_BYPASS_EN
  // The icc.C that the carry op would see is still being produced by the ALU
  // for the op in E; forward it instead of waiting.
  assign stall     = 1'b0;
  assign carry_src = e_cc ? bus.alu_c : icc_q[ICC_C];
`else
  logic carry_req;

  // Any carry-op request behind a cc op freezes both ports for one cycle so
  // that icc.C is up to date when the carry op is accepted.
  assign carry_req = (bus.req0_valid & uses_carry(bus.req0_op)) |
                     (bus.req1_valid & uses_carry(bus.req1_op));
  assign stall     = e_cc & carry_req;
  assign carry_src = icc_q[ICC_C];
`endif

  // --------------------------------------------------------------------------
  // Arbitration and handshake
  // --------------------------------------------------------------------------
  logic gnt0;
  logic gnt1;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (bus.req0_valid),
    .req1  (bus.req1_valid),
    .stall (stall),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  logic ready0;
  logic ready1;
  logic hs;

  assign ready0 = gnt0 & ~stall & ~reset;
  assign ready1 = gnt1 & ~stall & ~reset;

  // A grant implies the corresponding valid, so ready alone marks the
  // handshake.
  assign hs = ready0 | ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // --------------------------------------------------------------------------
  // Selected request
  // --------------------------------------------------------------------------
  op3_t         sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic         sel_cin;

  always_comb begin
    sel_op = bus.req0_op;
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    if (ready1) begin
      sel_op = bus.req1_op;
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
    end
    sel_cin = uses_carry(sel_op) ? carry_src : 1'b0;
  end

  // --------------------------------------------------------------------------
  // Stage E: issue register driving the ALU
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      e_ctl <= '0;
      e_a   <= '0;
      e_b   <= '0;
    end else begin
      e_ctl.valid <= hs;
      // Operands hold their last value while E is empty.
      if (hs) begin
        e_ctl.port <= ready1;
        e_ctl.op   <= sel_op;
        e_ctl.cin  <= sel_cin;
        e_a        <= sel_a;
        e_b        <= sel_b;
      end
    end
  end

  assign bus.alu_op  = e_ctl.op;
  assign bus.alu_a   = e_a;
  assign bus.alu_b   = e_b;
  assign bus.alu_cin = e_ctl.cin;

  // --------------------------------------------------------------------------
  // Stage W: writeback / response register
  // --------------------------------------------------------------------------
  logic [3:0] alu_flags;

  assign alu_flags = {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_port  <= 1'b0;
      w_res   <= '0;
      w_icc   <= '0;
    end else begin
      w_valid <= e_ctl.valid;
      if (e_ctl.valid) begin
        w_port <= e_ctl.port;
        w_res  <= bus.alu_res;
        w_icc  <= alu_flags;
      end
    end
  end

  assign bus.rsp_valid = w_valid;
  assign bus.rsp_port  = w_port;
  assign bus.rsp_res   = w_res;
  assign bus.rsp_icc   = w_icc;

  // --------------------------------------------------------------------------
  // Architectural icc: an external write overrides a same-edge cc update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      icc_q <= '0;
    end else if (bus.icc_wr_en) begin
      icc_q <= bus.icc_wr_data;
    end else if (e_cc) begin
      icc_q <= alu_flags;
    end
  end

  assign bus.icc = icc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl. Includes a
//               behavioural integer ALU hooked to the alu_* bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int W   = 32;
  localparam int OPW = 6;

  localparam logic [5:0] OP_ADDCC = 6'b010000;
  localparam logic [5:0] OP_ADDX  = 6'b001000;
  localparam logic [5:0] OP_SUBX  = 6'b001100;
  localparam logic [5:0] OP_AND   = 6'b000001;
  localparam logic [5:0] OP_OR    = 6'b000010;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  alu_issue_ctrl_if #(.W(W), .OPW(OPW)) bus ();

  alu_issue_ctrl #(.W(W), .OPW(OPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural ALU (SPARC-style op3 low nibble)
  // --------------------------------------------------------------------------
  logic [W:0]   m_sum;
  logic [W-1:0] m_res;
  logic         m_v;
  logic         m_c;

  always_comb begin
    m_sum = '0;
    m_res = '0;
    m_v   = 1'b0;
    m_c   = 1'b0;
    case (bus.alu_op[3:0])
      4'h0, 4'h8: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} +
                {{W{1'b0}}, (bus.alu_op[3] & bus.alu_cin)};
        m_res = m_sum[W-1:0];
        m_c   = m_sum[W];
        m_v   = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (m_res[W-1] != bus.alu_a[W-1]);
      end
      4'h4, 4'hC: begin
        m_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} -
                {{W{1'b0}}, (bus.alu_op[3] & bus.alu_cin)};
        m_res = m_sum[W-1:0];
        m_c   = m_sum[W];
        m_v   = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (m_res[W-1] != bus.alu_a[W-1]);
      end
      4'h1: m_res = bus.alu_a & bus.alu_b;
      4'h2: m_res = bus.alu_a | bus.alu_b;
      4'h3: m_res = bus.alu_a ^ bus.alu_b;
      4'h5: m_res = bus.alu_a & ~bus.alu_b;
      4'h6: m_res = bus.alu_a | ~bus.alu_b;
      4'h7: m_res = ~(bus.alu_a ^ bus.alu_b);
      default: m_res = '0;
    endcase
  end

  assign bus.alu_res = m_res;
  assign bus.alu_n   = m_res[W-1];
  assign bus.alu_z   = (m_res == '0);
  assign bus.alu_v   = m_v;
  assign bus.alu_c   = m_c;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid  = 1'b0;
    bus.req0_op     = '0;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_op     = '0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.icc_wr_en   = 1'b0;
    bus.icc_wr_data = '0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_AND;
    #1;
    total++; if (bus.req0_ready !== 1'b0) $display("FAIL reset_ready0: got %b expected 0", bus.req0_ready); else passed++;
    tick();
    tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else passed++;
    total++; if (bus.icc !== 4'b0000) $display("FAIL reset_icc: got %b expected 0000", bus.icc); else passed++;
    total++; if (bus.alu_op !== 6'd0 || bus.alu_a !== 32'd0 || bus.alu_cin !== 1'b0)
      $display("FAIL reset_alu_bus: got op=%h a=%h cin=%b expected 0/0/0", bus.alu_op, bus.alu_a, bus.alu_cin); else passed++;
    total++; if (bus.rsp_res !== 32'd0 || bus.rsp_icc !== 4'd0 || bus.rsp_port !== 1'b0)
      $display("FAIL reset_rsp: got res=%h icc=%b port=%b expected 0/0/0", bus.rsp_res, bus.rsp_icc, bus.rsp_port); else passed++;
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_addcc();
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_ADDCC;
    bus.req0_a     = 32'h7FFF_FFFF;
    bus.req0_b     = 32'h0000_0001;
    #1;
    total++; if (bus.req0_ready !== 1'b1) $display("FAIL addcc_ready: got %b expected 1", bus.req0_ready); else passed++;
    tick();
    bus.req0_valid = 1'b0;
    total++; if (bus.alu_a !== 32'h7FFF_FFFF || bus.alu_op !== OP_ADDCC)
      $display("FAIL addcc_issue: got op=%h a=%h expected %h/7fffffff", bus.alu_op, bus.alu_a, OP_ADDCC); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL addcc_latency: got rsp_valid=%b expected 0", bus.rsp_valid); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== 1'b0 || bus.rsp_res !== 32'h8000_0000)
      $display("FAIL addcc_rsp: got v=%b port=%b res=%h expected 1/0/80000000", bus.rsp_valid, bus.rsp_port, bus.rsp_res); else passed++;
    total++; if (bus.rsp_icc !== 4'b1010) $display("FAIL addcc_rsp_icc: got %b expected 1010", bus.rsp_icc); else passed++;
    total++; if (bus.icc !== 4'b1010) $display("FAIL addcc_icc: got %b expected 1010", bus.icc); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL addcc_pulse: got rsp_valid=%b expected 0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_ADDCC;
    bus.req0_a     = 32'hFFFF_FFFF;
    bus.req0_b     = 32'h0000_0001;
    tick();
    bus.req0_op = OP_ADDX;
    bus.req0_a  = 32'd0;
    bus.req0_b  = 32'd0;
    #1;
`ifdef ICC_BYPASS_EN
    total++; if (bus.req0_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", bus.req0_ready); else passed++;
    tick();
    bus.req0_valid = 1'b0;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'd0 || bus.icc !== 4'b0101)
      $display("FAIL b2b_first: got v=%b res=%h icc=%b expected 1/0/0101", bus.rsp_valid, bus.rsp_res, bus.icc); else passed++;
    total++; if (bus.alu_cin !== 1'b1) $display("FAIL b2b_cin: got %b expected 1", bus.alu_cin); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'd1)
      $display("FAIL b2b_addx: got v=%b res=%h expected 1/00000001", bus.rsp_valid, bus.rsp_res); else passed++;
`else
    total++; if (bus.req0_ready !== 1'b0) $display("FAIL b2b_stall: got ready=%b expected 0", bus.req0_ready); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'd0 || bus.icc !== 4'b0101)
      $display("FAIL b2b_first: got v=%b res=%h icc=%b expected 1/0/0101", bus.rsp_valid, bus.rsp_res, bus.icc); else passed++;
    total++; if (bus.req0_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", bus.req0_ready); else passed++;
    tick();
    bus.req0_valid = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_bubble: got rsp_valid=%b expected 0", bus.rsp_valid); else passed++;
    total++; if (bus.alu_cin !== 1'b1) $display("FAIL b2b_cin: got %b expected 1", bus.alu_cin); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'd1)
      $display("FAIL b2b_addx: got v=%b res=%h expected 1/00000001", bus.rsp_valid, bus.rsp_res); else passed++;
`endif
    tick();
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_AND;
    bus.req0_a     = 32'hF0F0_F0F0;
    bus.req0_b     = 32'hFF00_FF00;
    bus.req1_valid = 1'b1;
    bus.req1_op    = OP_AND;
    bus.req1_a     = 32'h0F0F_0F0F;
    bus.req1_b     = 32'hFF00_FF00;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        total++; if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1))
          $display("FAIL rr_grant%0d: got r0=%b r1=%b expected %b/%b", i, bus.req0_ready, bus.req1_ready, i % 2 == 0, i % 2 == 1); else passed++;
      end
      tick();
      if (i >= 1) begin
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== ((i - 1) % 2 == 1) ||
                     bus.rsp_res !== (((i - 1) % 2 == 1) ? 32'h0F00_0F00 : 32'hF000_F000))
          $display("FAIL rr_rsp%0d: got v=%b port=%b res=%h expected port %0d", i - 1, bus.rsp_valid, bus.rsp_port, bus.rsp_res, (i - 1) % 2); else passed++;
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_icc_hold();
    bus.icc_wr_en   = 1'b1;
    bus.icc_wr_data = 4'b1111;
    tick();
    bus.icc_wr_en = 1'b0;
    total++; if (bus.icc !== 4'b1111) $display("FAIL icc_ext_write: got %b expected 1111", bus.icc); else passed++;
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_OR;
    bus.req0_a     = 32'd1;
    bus.req0_b     = 32'd2;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    total++; if (bus.rsp_res !== 32'd3 || bus.rsp_icc !== 4'b0000 || bus.icc !== 4'b1111)
      $display("FAIL or_icc_hold: got res=%h rsp_icc=%b icc=%b expected 3/0000/1111", bus.rsp_res, bus.rsp_icc, bus.icc); else passed++;
    // SUBX takes icc.C=1 as borrow: 5 - 2 - 1 = 2
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_SUBX;
    bus.req0_a     = 32'd5;
    bus.req0_b     = 32'd2;
    tick();
    bus.req0_valid = 1'b0;
    total++; if (bus.alu_cin !== 1'b1) $display("FAIL subx_cin: got %b expected 1", bus.alu_cin); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 32'd2 || bus.icc !== 4'b1111)
      $display("FAIL subx_res: got v=%b res=%h icc=%b expected 1/2/1111", bus.rsp_valid, bus.rsp_res, bus.icc); else passed++;
    tick();
  endtask

  task automatic test_icc_write_priority();
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_ADDCC;
    bus.req0_a     = 32'h7FFF_FFFF;
    bus.req0_b     = 32'd1;
    tick();
    bus.req0_valid  = 1'b0;
    bus.icc_wr_en   = 1'b1;
    bus.icc_wr_data = 4'b0000;
    tick();
    bus.icc_wr_en = 1'b0;
    total++; if (bus.icc !== 4'b0000) $display("FAIL icc_wr_priority: got %b expected 0000", bus.icc); else passed++;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_icc !== 4'b1010)
      $display("FAIL icc_wr_rsp: got v=%b rsp_icc=%b expected 1/1010", bus.rsp_valid, bus.rsp_icc); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_op();
    bus.req0_valid = 1'b1;
    bus.req0_op    = OP_ADDCC;
    bus.req0_a     = 32'h7FFF_FFFF;
    bus.req0_b     = 32'd1;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_op    = OP_ADDCC;
    bus.req1_a     = 32'hFFFF_FFFF;
    bus.req1_b     = 32'd1;
    #1;
    total++; if (bus.req1_ready !== 1'b1) $display("FAIL mid_ready1: got %b expected 1", bus.req1_ready); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1) $display("FAIL mid_w_full: got rsp_valid=%b expected 1", bus.rsp_valid); else passed++;
    reset          = 1'b1;
    bus.req1_valid = 1'b0;
    tick();
    total++; if (bus.rsp_valid !== 1'b0 || bus.icc !== 4'b0000 || bus.alu_cin !== 1'b0 || bus.alu_op !== 6'd0)
      $display("FAIL mid_reset: got v=%b icc=%b cin=%b op=%h expected 0/0000/0/00", bus.rsp_valid, bus.icc, bus.alu_cin, bus.alu_op); else passed++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_discard%0d: got rsp_valid=%b expected 0", i, bus.rsp_valid); else passed++;
    end
  endtask

  // --------------------------------------------------------------------------
  // Sequence
  // --------------------------------------------------------------------------
  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_addcc();
    test_back_to_back();
    test_round_robin();
    test_icc_hold();
    test_icc_write_priority();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
